snn_mem_loader: RTL and testbench
=================================

# snn_mem_loader

Serial configuration loader that drives the write port of the SNN weight/delay memory. It receives SPI-mode-0 frames on three pins (`sclk`, `cs_n`, `mosi`) and decodes a command byte and a start-address byte. Each following data byte becomes a single-cycle write strobe to the memory, with auto-incrementing, wrapping addresses. The block sits between the chip's input pins and the memory's `addr`/`data_in`/`write_enable` port.

## Interface
- `DEPTH`, 162, number of memory locations; the address range is 0..DEPTH-1.
- `AW`, `$clog2(DEPTH)` (8), memory address width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `sclk`  in  1  serial clock, asynchronous to `clk`; idles low.
- `cs_n`  in  1  frame select, active-low, asynchronous.
- `mosi`  in  1  serial data in, MSB first, valid on `sclk` rising edge.
- `miso`  out  1  serial data out for readback.
- `mem_rdata`  in  8  combinational read data from the memory at `mem_addr`.
- `mem_addr`  out  AW  memory address.
- `mem_data`  out  8  memory write data.
- `mem_we`  out  1  memory write strobe, one `clk` cycle per byte.
- `frame_active`  out  1  high while a frame is being decoded.
- `err`  out  1  sticky: set on an out-of-range address or unknown command; cleared at the next frame start.

## Operation
- Input synchronisation:
  - `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchroniser.
  - Edges are detected on the synchronised `sclk` and `cs_n`.
- State machine with states IDLE, CMD, ADDR, DATA, DROP.
  - IDLE → CMD on a synchronised `cs_n` falling edge. On that transition: bit counter = 0, `err` = 0, `frame_active` = 1.
  - In every non-IDLE state, a synchronised `sclk` rise shifts `mosi` into an 8-bit shift register. The 8th bit completes a byte.
  - CMD byte handling:
    - 0xA5 sets mode to write.
    - 0x5A sets mode to read.
    - Any other value sets `err` and moves to DROP.
  - ADDR byte handling:
    - A value below DEPTH is loaded into `mem_addr`, and the state moves to DATA.
    - A value of DEPTH or above sets `err` and moves to DROP.
  - DATA, write mode: each completed byte sets `mem_data` = byte and `mem_we` = 1 for one `clk` cycle. On the next cycle `mem_addr` increments.
  - DATA, read mode: no writes. After each completed byte `mem_addr` increments.
  - Address wrap: DEPTH-1 increments to 0.
  - DROP: ignores all bits until the frame ends.
  - Any state → IDLE on a synchronised `cs_n` rising edge. A partial byte is discarded, `frame_active` = 0, and `err` holds its value.
- Reset values: `mem_addr` = 0, `mem_data` = 0, `mem_we` = 0, `miso` = 0, `frame_active` = 0, `err` = 0, state = IDLE.
- A reset mid-frame aborts immediately. After release, the block waits for a fresh `cs_n` fall and ignores any remainder of the frame still in flight.

## Timing
- Requirement: `sclk` high and low phases must each be at least 4 `clk` periods.
- Write latency: `mem_we` asserts 3 `clk` cycles after the raw `sclk` rise carrying bit 0 (LSB) of a data byte. This is 2 synchroniser cycles plus 1 register cycle.
- `mem_addr` and `mem_data` are stable during the `mem_we` cycle. `mem_addr` advances on the cycle after `mem_we` deasserts.
- `mem_we` is never asserted outside state DATA in write mode.
- `cs_n` rise and the 8th `sclk` rise detected in the same `clk` cycle: the byte completes and is written first, then the state goes to IDLE.

## Configuration
- `SNN_LOADER_READBACK_EN` defined: read mode (0x5A) is supported.
  - On entry to DATA, and after each byte, `mem_rdata` is loaded into the TX shift register.
  - `miso` presents the MSB and shifts on each synchronised `sclk` fall.
- `SNN_LOADER_READBACK_EN` undefined:
  - 0x5A is treated as an unknown command (sets `err`, state → DROP).
  - `miso` is tied to 0 and no TX register is built.

## Test plan
- Write frame A5, 05, 11, 22, 33 → three `mem_we` pulses with (addr, data) = (5, 0x11), (6, 0x22), (7, 0x33); `err` = 0; final `mem_addr` = 8.
- Wrap: A5, A1 (161), 44, 55 → writes (161, 0x44) then (0, 0x55).
- Bad address A5, C8 (200), 66 → no `mem_we`; `err` = 1 after the frame; the next valid frame clears `err`.
- `cs_n` raised after 5 bits of a data byte → no write for that byte; `frame_active` = 0; the next frame decodes a fresh CMD byte correctly.
- `rst_n` pulsed low mid-ADDR byte → all outputs return to their reset values; the rest of that frame produces no `mem_we`.
- With readback enabled: memory preloaded with mem[10] = 0x3C, mem[11] = 0xC3; frame 5A, 0A, then 16 clocks → `miso` bit stream 0x3C, 0xC3; no `mem_we` during the frame.

Source files
------------

// File: rtl/snn_mem_loader.sv
// SPI-mode-0 configuration loader driving the SNN weight/delay memory write port.
// Optional readback (command 0x5A, data on miso) is built when SNN_LOADER_READBACK_EN is defined.
module snn_mem_loader #(
    parameter int unsigned DEPTH = 162,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic          mosi,
    output logic          miso,
    input  logic [7:0]    mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_we,
    output logic          frame_active,
    output logic          err
);

    localparam logic [7:0]    CMD_WR    = 8'hA5;
    localparam logic [7:0]    CMD_RD    = 8'h5A;
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DROP} state_t;

    state_t      state;
    logic [2:0]  sclk_p;
    logic [2:0]  cs_p;
    logic [1:0]  mosi_p;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    // cs_n synchroniser resets to "selected" so a frame still in flight at
    // reset release produces no falling edge and is ignored until it ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p <= '0;
            cs_p   <= '0;
            mosi_p <= '0;
        end else begin
            sclk_p <= {sclk_p[1:0], sclk};
            cs_p   <= {cs_p[1:0], cs_n};
            mosi_p <= {mosi_p[0], mosi};
        end
    end

    logic          sclk_rise;
    logic          sclk_fall;
    logic          cs_fall;
    logic          cs_rise;
    logic [7:0]    byte_nxt;
    logic [AW-1:0] addr_inc;

    assign sclk_rise = sclk_p[1] & ~sclk_p[2];
    assign sclk_fall = ~sclk_p[1] & sclk_p[2];
    assign cs_fall   = ~cs_p[1] & cs_p[2];
    assign cs_rise   = cs_p[1] & ~cs_p[2];
    assign byte_nxt  = {shreg[6:0], mosi_p[1]};
    assign addr_inc  = (mem_addr == ADDR_LAST) ? '0 : mem_addr + AW'(1);

`ifdef SNN_LOADER_READBACK_EN
    logic       rd_mode;
    logic       tx_load;
    logic [7:0] tx_sr;
    assign miso = tx_sr[7];
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign miso = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mem_we       <= 1'b0;
            frame_active <= 1'b0;
            err          <= 1'b0;
`ifdef SNN_LOADER_READBACK_EN
            rd_mode      <= 1'b0;
            tx_load      <= 1'b0;
            tx_sr        <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            // Address advances the cycle after each write strobe.
            if (mem_we) begin
                mem_addr <= addr_inc;
            end
`ifdef SNN_LOADER_READBACK_EN
            tx_load <= 1'b0;
            if (tx_load) begin
                tx_sr <= mem_rdata;
            end else if (sclk_fall && state == ST_DATA && rd_mode && bit_cnt != 3'd0) begin
                tx_sr <= {tx_sr[6:0], 1'b0};
            end
`endif
            if (state == ST_IDLE) begin
                if (cs_fall) begin
                    state        <= ST_CMD;
                    bit_cnt      <= '0;
                    err          <= 1'b0;
                    frame_active <= 1'b1;
                end
            end else begin
                if (sclk_rise) begin
                    shreg   <= byte_nxt;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            ST_CMD: begin
                                if (byte_nxt == CMD_WR) begin
                                    state <= ST_ADDR;
`ifdef SNN_LOADER_READBACK_EN
                                    rd_mode <= 1'b0;
                                end else if (byte_nxt == CMD_RD) begin
                                    state   <= ST_ADDR;
                                    rd_mode <= 1'b1;
`endif
                                end else begin
                                    err   <= 1'b1;
                                    state <= ST_DROP;
                                end
                            end
                            ST_ADDR: begin
                                if (32'(byte_nxt) < DEPTH) begin
                                    mem_addr <= AW'(byte_nxt);
                                    state    <= ST_DATA;
`ifdef SNN_LOADER_READBACK_EN
                                    tx_load  <= rd_mode;
`endif
                                end else begin
                                    err   <= 1'b1;
                                    state <= ST_DROP;
                                end
                            end
                            ST_DATA: begin
`ifdef SNN_LOADER_READBACK_EN
                                if (rd_mode) begin
                                    mem_addr <= addr_inc;
                                    tx_load  <= 1'b1;
                                end else begin
                                    mem_data <= byte_nxt;
                                    mem_we   <= 1'b1;
                                end
`else
                                mem_data <= byte_nxt;
                                mem_we   <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                // Frame end overrides any state change above; a completing byte still lands.
                if (cs_rise) begin
                    state        <= ST_IDLE;
                    frame_active <= 1'b0;
`ifdef SNN_LOADER_READBACK_EN
                    rd_mode      <= 1'b0;
                    tx_sr        <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_snn_mem_loader.sv
// Directed bench for snn_mem_loader: SPI frames bit-banged on sclk/cs_n/mosi, writes logged from mem_we.
module tb_snn_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] mem_rdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       frame_active;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rise_cyc = 0;

    logic [7:0] mem [0:161];
    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wl[$];
    logic [7:0] rx0;
    logic [7:0] rx1;

    snn_mem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .frame_active (frame_active),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    assign mem_rdata = mem[mem_addr];

    // Write log sampled away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            wl.push_back(cyc - rise_cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send the top n bits of b MSB first; miso is sampled just before each rise.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            mosi = b[i];
            wait_neg(5);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            rise_cyc = cyc;
            wait_neg(6);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] rx;
        spi_bits(b, 8, rx);
    endtask

    task automatic frame_start();
        @(negedge clk);
        cs_n = 1'b0;
        wait_neg(6);
    endtask

    task automatic frame_end();
        wait_neg(6);
        cs_n = 1'b1;
        wait_neg(8);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wl.delete();
    endtask

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < 162; i++) mem[i] = 8'h00;
        wait_neg(4);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_frame_active", 32'(frame_active), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        wait_neg(4);

        // Basic write frame
        clear_log();
        frame_start();
        send(8'hA5);
        check("t1_frame_active", 32'(frame_active), 32'd1);
        send(8'h05); send(8'h11); send(8'h22); send(8'h33);
        frame_end();
        check("t1_nwrites", 32'(wa.size()), 32'd3);
        if (wa.size() == 3) begin
            check("t1_a0", 32'(wa[0]), 32'd5);   check("t1_d0", 32'(wd[0]), 32'h11);
            check("t1_a1", 32'(wa[1]), 32'd6);   check("t1_d1", 32'(wd[1]), 32'h22);
            check("t1_a2", 32'(wa[2]), 32'd7);   check("t1_d2", 32'(wd[2]), 32'h33);
            check("t1_latency", 32'(wl[0]), 32'd3);
        end
        check("t1_err", 32'(err), 32'd0);
        check("t1_final_addr", 32'(mem_addr), 32'd8);
        check("t1_frame_done", 32'(frame_active), 32'd0);

        // Address wrap at DEPTH-1
        clear_log();
        frame_start();
        send(8'hA5); send(8'hA1); send(8'h44); send(8'h55);
        frame_end();
        check("t2_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            check("t2_a0", 32'(wa[0]), 32'd161); check("t2_d0", 32'(wd[0]), 32'h44);
            check("t2_a1", 32'(wa[1]), 32'd0);   check("t2_d1", 32'(wd[1]), 32'h55);
        end
        check("t2_final_addr", 32'(mem_addr), 32'd1);

        // Out-of-range address
        clear_log();
        frame_start();
        send(8'hA5); send(8'hC8); send(8'h66);
        frame_end();
        check("t3_nwrites", 32'(wa.size()), 32'd0);
        check("t3_err", 32'(err), 32'd1);
        frame_start();
        check("t3_err_cleared", 32'(err), 32'd0);
        send(8'hA5); send(8'h00); send(8'h77);
        frame_end();
        check("t3b_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t3b_a0", 32'(wa[0]), 32'd0); check("t3b_d0", 32'(wd[0]), 32'h77);
        end
        check("t3b_err", 32'(err), 32'd0);

        // Frame aborted after 5 bits of a data byte
        clear_log();
        frame_start();
        send(8'hA5); send(8'h10);
        spi_bits(8'hF0, 5, rx);
        frame_end();
        check("t4_nwrites", 32'(wa.size()), 32'd0);
        check("t4_frame_active", 32'(frame_active), 32'd0);
        frame_start();
        send(8'hA5); send(8'h20); send(8'h99);
        frame_end();
        check("t4b_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() == 1) begin
            check("t4b_a0", 32'(wa[0]), 32'd32); check("t4b_d0", 32'(wd[0]), 32'h99);
        end

        // Unknown command
        clear_log();
        frame_start();
        send(8'h33); send(8'h01); send(8'hAB);
        frame_end();
        check("t5_unknown_err", 32'(err), 32'd1);
        check("t5_nwrites", 32'(wa.size()), 32'd0);

        // Reset pulsed in the middle of the ADDR byte
        frame_start();
        send(8'hA5);
        spi_bits(8'h0C, 4, rx);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("t6_rst_frame_active", 32'(frame_active), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        check("t6_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t6_rst_mem_data", 32'(mem_data), 32'd0);
        wait_neg(3);
        rst_n = 1'b1;
        spi_bits(8'hC0, 4, rx);
        send(8'h12);
        check("t6_mid_frame_active", 32'(frame_active), 32'd0);
        frame_end();
        check("t6_nwrites", 32'(wa.size()), 32'd0);
        check("t6_mem_addr", 32'(mem_addr), 32'd0);

        // Read command
        clear_log();
        mem[10] = 8'h3C;
        mem[11] = 8'hC3;
        frame_start();
        send(8'h5A); send(8'h0A);
        spi_bits(8'h00, 8, rx0);
        spi_bits(8'h00, 8, rx1);
        frame_end();
        check("t7_nwrites", 32'(wa.size()), 32'd0);
`ifdef SNN_LOADER_READBACK_EN
        check("t7_rx0", 32'(rx0), 32'h3C);
        check("t7_rx1", 32'(rx1), 32'hC3);
        check("t7_err", 32'(err), 32'd0);
        check("t7_final_addr", 32'(mem_addr), 32'd12);
`else
        check("t7_err", 32'(err), 32'd1);
        check("t7_rx0", 32'(rx0), 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
